// File: rtl/lfsr_roller.sv
// Slowing-roll random generator: free-running LFSR sampled at a period that doubles per stage,
// with catch/freeze and a small history of committed results that can be stepped through.
module lfsr_roller #(
    parameter int              WIDTH       = 4,
    parameter logic [WIDTH-1:0] TAPS       = 4'b0011,
    parameter logic [WIDTH-1:0] SEED       = 4'd3,
    parameter int              STAGES      = 5,
    parameter int              BASE_PERIOD = 3125000,
    parameter int              STAGE_LEN   = 100000000,
    parameter int              HIST_DEPTH  = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_start,
    input  logic                          i_catch,
    input  logic                          i_prev,
    output logic [WIDTH-1:0]              o_random_out,
    output logic [$clog2(HIST_DEPTH+1)-1:0] o_hist_idx,
    output logic                          o_rolling,
    output logic                          o_done
);
    localparam longint PER_MAX = longint'(BASE_PERIOD) << (STAGES - 1);
    localparam int     PER_W   = $clog2(PER_MAX + 1);
    localparam int     DW_W    = (STAGE_LEN > 1) ? $clog2(STAGE_LEN) : 1;
    localparam int     STG_W   = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam int     IDX_W   = $clog2(HIST_DEPTH + 1);

    localparam logic [PER_W-1:0] BASE_P   = PER_W'(BASE_PERIOD);
    localparam logic [DW_W-1:0]  DW_LAST  = DW_W'(STAGE_LEN - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGES - 1);
    localparam logic [IDX_W-1:0] HIST_MAX = IDX_W'(HIST_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ROLL, S_HOLD, S_REVIEW} state_t;

    state_t             state_q, state_d, ret_q, ret_d;
    logic [WIDTH-1:0]   lfsr_q, lfsr_d, value_q, value_d;
    logic [WIDTH-1:0]   hist_q [HIST_DEPTH];
    logic [IDX_W-1:0]   hist_cnt_q, idx_q, idx_d;
    logic [STG_W-1:0]   stage_q, stage_d;
    logic [DW_W-1:0]    dwell_q, dwell_d;
    logic [PER_W-1:0]   per_q, per_d, per_last;
    logic               done_q, done_d;
    logic               commit;
    logic [WIDTH-1:0]   commit_val;
    logic               in_roll;
    logic [WIDTH-1:0]   rd_val;

    assign per_last = (BASE_P << stage_q) - PER_W'(1);
    assign in_roll  = (state_q == S_ROLL) || (state_q == S_HOLD) ||
                      ((state_q == S_REVIEW) && ((ret_q == S_ROLL) || (ret_q == S_HOLD)));

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        value_d    = value_q;
        idx_d      = idx_q;
        stage_d    = stage_q;
        dwell_d    = dwell_q;
        per_d      = per_q;
        done_d     = 1'b0;
        commit     = 1'b0;
        commit_val = value_q;
        lfsr_d     = (lfsr_q == '0) ? SEED : {^(lfsr_q & TAPS), lfsr_q[WIDTH-1:1]};

        if (i_prev) begin
            if (state_q != S_REVIEW) begin
                if (hist_cnt_q != '0) begin
                    state_d = S_REVIEW;
                    ret_d   = state_q;
                    idx_d   = IDX_W'(1);
                end
            end else if (idx_q < hist_cnt_q) begin
                idx_d = idx_q + IDX_W'(1);
            end else begin
                idx_d   = '0;
                state_d = ret_q;
            end
        end else if (i_start) begin
            commit  = in_roll;
            state_d = S_ROLL;
            stage_d = '0;
            dwell_d = '0;
            per_d   = '0;
            idx_d   = '0;
            value_d = lfsr_q;
        end else if (i_catch) begin
            case (state_q)
                S_ROLL:   state_d = S_HOLD;
                S_HOLD:   state_d = S_ROLL;
                S_REVIEW: begin
                    idx_d   = '0;
                    state_d = ret_q;
                end
                default:  state_d = state_q;
            endcase
        end else if (state_q == S_ROLL) begin
            if (per_q == per_last) begin
                value_d = lfsr_q;
                per_d   = '0;
            end else begin
                per_d = per_q + PER_W'(1);
            end
            if (dwell_q == DW_LAST) begin
                per_d   = '0;
                dwell_d = '0;
                if (stage_q < STG_LAST) begin
                    stage_d = stage_q + STG_W'(1);
                end else begin
                    // A sample landing on the final edge is the value that gets committed.
                    commit     = 1'b1;
                    commit_val = value_d;
                    state_d    = S_IDLE;
                    done_d     = 1'b1;
                end
            end else begin
                dwell_d = dwell_q + DW_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            lfsr_q     <= SEED;
            value_q    <= '0;
            idx_q      <= '0;
            stage_q    <= '0;
            dwell_q    <= '0;
            per_q      <= '0;
            done_q     <= 1'b0;
            hist_cnt_q <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) hist_q[i] <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            lfsr_q  <= lfsr_d;
            value_q <= value_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            dwell_q <= dwell_d;
            per_q   <= per_d;
            done_q  <= done_d;
            if (commit) begin
                for (int i = HIST_DEPTH - 1; i > 0; i--) hist_q[i] <= hist_q[i-1];
                hist_q[0] <= commit_val;
                if (hist_cnt_q != HIST_MAX) hist_cnt_q <= hist_cnt_q + IDX_W'(1);
            end
        end
    end

    always_comb begin
        rd_val = value_q;
        for (int i = 0; i < HIST_DEPTH; i++) begin
            if (idx_q == IDX_W'(i + 1)) rd_val = hist_q[i];
        end
    end

    assign o_random_out = rd_val;
    assign o_hist_idx   = idx_q;
    assign o_rolling    = (state_q == S_ROLL);
    assign o_done       = done_q;
endmodule

// File: tb/tb_lfsr_roller.sv
// Directed bench for lfsr_roller with short stages (3 stages, period 2, dwell 16, history 2).
module tb_lfsr_roller;
    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_catch = 1'b0;
    logic       i_prev = 1'b0;
    logic [3:0] o_random_out;
    logic [1:0] o_hist_idx;
    logic       o_rolling;
    logic       o_done;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_roller #(
        .WIDTH(4), .TAPS(4'b0011), .SEED(4'd3), .STAGES(3),
        .BASE_PERIOD(2), .STAGE_LEN(16), .HIST_DEPTH(2)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_catch(i_catch),
        .i_prev(i_prev), .o_random_out(o_random_out), .o_hist_idx(o_hist_idx),
        .o_rolling(o_rolling), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic pulse(input logic s, input logic c, input logic p);
        i_start = s; i_catch = c; i_prev = p;
        tick();
        i_start = 1'b0; i_catch = 1'b0; i_prev = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_roll(input string tag, output logic [3:0] v);
        bit seen;
        seen = 1'b0;
        v = 'x;
        pulse(1'b1, 1'b0, 1'b0);
        for (int c = 1; c <= 100 && !seen; c++) begin
            tick();
            if (o_done) begin
                seen = 1'b1;
                v = o_random_out;
            end
        end
        if (!seen) chk({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq [15] = '{4'd3, 4'd1, 4'd8, 4'd4, 4'd2, 4'd9, 4'd12, 4'd6,
                                 4'd11, 4'd5, 4'd10, 4'd13, 4'd14, 4'd15, 4'd7};
        logic [3:0] prev_v, fin, hold_v, va, vb, vc, v;
        int upd [3];
        int roll_cnt, done_cnt, done_at, resume_cnt;
        bit frozen_bad;

        // Reset state
        #3;
        chk("rst_out", 32'(o_random_out), 0);
        chk("rst_idx", 32'(o_hist_idx), 0);
        chk("rst_rolling", 32'(o_rolling), 0);
        chk("rst_done", 32'(o_done), 0);

        // Free-running LFSR: a start on every edge exposes the pre-advance value
        do_reset();
        i_start = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("seq_%0d", k), 32'(o_random_out), 32'(seq[k % 15]));
        end
        i_start = 1'b0;

        // Natural roll
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        chk("roll_first", 32'(o_random_out), 3);
        prev_v = o_random_out;
        upd = '{0, 0, 0};
        roll_cnt = o_rolling ? 1 : 0;
        done_cnt = 0;
        done_at = -1;
        fin = '0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (o_random_out != prev_v && c <= 48) upd[(c - 1) / 16]++;
            prev_v = o_random_out;
            if (o_rolling) roll_cnt++;
            if (o_done) begin
                done_cnt++;
                done_at = c;
                fin = o_random_out;
            end
        end
        chk("upd_stage0", 32'(upd[0]), 8);
        chk("upd_stage1", 32'(upd[1]), 4);
        chk("upd_stage2", 32'(upd[2]), 2);
        chk("roll_cycles", 32'(roll_cnt), 48);
        chk("done_count", 32'(done_cnt), 1);
        chk("done_at", 32'(done_at), 48);
        pulse(1'b0, 1'b0, 1'b1);
        chk("roll_hist_idx", 32'(o_hist_idx), 1);
        chk("roll_hist0", 32'(o_random_out), 32'(fin));
        pulse(1'b0, 1'b1, 1'b0);
        chk("roll_review_exit", 32'(o_hist_idx), 0);

        // Catch at the 6th edge (5 ROLL edges done), release 99 edges later
        pulse(1'b1, 1'b0, 1'b0);
        frozen_bad = 1'b0;
        resume_cnt = 0;
        done_at = -1;
        hold_v = '0;
        for (int c = 1; c <= 200; c++) begin
            i_catch = (c == 6 || c == 105);
            tick();
            i_catch = 1'b0;
            if (c == 6) hold_v = o_random_out;
            if (c >= 6 && c <= 105 && o_random_out != hold_v) frozen_bad = 1'b1;
            if (c >= 6 && c <= 104 && o_rolling) frozen_bad = 1'b1;
            if (c >= 105 && o_rolling) resume_cnt++;
            if (o_done && done_at < 0) done_at = c;
        end
        chk("catch_frozen", 32'(frozen_bad), 0);
        chk("catch_remaining", 32'(resume_cnt), 43);
        chk("catch_done_at", 32'(done_at), 148);

        // History depth 2: third roll pushes out the first
        do_reset();
        run_roll("roll_a", va);
        run_roll("roll_b", vb);
        run_roll("roll_c", vc);
        pulse(1'b0, 1'b0, 1'b1);
        chk("hist_idx1", 32'(o_hist_idx), 1);
        chk("hist_val1", 32'(o_random_out), 32'(vc));
        pulse(1'b0, 1'b0, 1'b1);
        chk("hist_idx2", 32'(o_hist_idx), 2);
        chk("hist_val2", 32'(o_random_out), 32'(vb));
        pulse(1'b0, 1'b0, 1'b1);
        chk("hist_idx0", 32'(o_hist_idx), 0);
        chk("hist_live", 32'(o_random_out), 32'(vc));

        // Simultaneous prev+start in ROLL, then start from REVIEW
        pulse(1'b1, 1'b0, 1'b0);
        repeat (10) tick();
        v = o_random_out;
        pulse(1'b1, 1'b0, 1'b1);
        chk("simul_idx", 32'(o_hist_idx), 1);
        chk("simul_val", 32'(o_random_out), 32'(vc));
        chk("simul_rolling", 32'(o_rolling), 0);
        pulse(1'b0, 1'b1, 1'b0);
        chk("simul_resume_rolling", 32'(o_rolling), 1);
        chk("simul_resume_val", 32'(o_random_out), 32'(v));
        pulse(1'b0, 1'b0, 1'b1);
        chk("rev_enter_idx", 32'(o_hist_idx), 1);
        pulse(1'b1, 1'b0, 1'b0);
        chk("rev_start_idx", 32'(o_hist_idx), 0);
        chk("rev_start_rolling", 32'(o_rolling), 1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("rev_commit_idx", 32'(o_hist_idx), 1);
        chk("rev_commit_val", 32'(o_random_out), 32'(v));
        pulse(1'b0, 1'b0, 1'b1);
        chk("rev_commit_older", 32'(o_random_out), 32'(vc));

        // Asynchronous reset during stage 1
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        repeat (20) tick();
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_out", 32'(o_random_out), 0);
        chk("midrst_idx", 32'(o_hist_idx), 0);
        chk("midrst_rolling", 32'(o_rolling), 0);
        chk("midrst_done", 32'(o_done), 0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        pulse(1'b1, 1'b0, 1'b0);
        chk("postrst_seed", 32'(o_random_out), 3);
        pulse(1'b0, 1'b0, 1'b1);
        chk("empty_prev_idx", 32'(o_hist_idx), 0);
        chk("empty_prev_rolling", 32'(o_rolling), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
